// File: rtl/cordic_pkg.sv
// Shared constants, state encoding and saturation helper for the CORDIC front end.
// Holds the IEEE-754 single field layout used by the float-to-theta aligner.
package cordic_pkg;

    localparam int WIDTH_DEF = 24;

    localparam int SIGN_BIT  = 31;
    localparam int EXP_MSB   = 30;
    localparam int EXP_LSB   = 23;
    localparam int MANT_MSB  = 22;
    localparam int MANT_BITS = 23;

    localparam int EXP_BIAS = 127;
    // Any exponent at or above this means |x| >= 2, Inf or NaN.
    localparam int EXP_OVF = EXP_BIAS + 1;
    localparam logic [7:0] EXP_ALL_ONES = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        ALIGN,
        SIGN
    } state_e;

    // Largest positive or most negative two's complement theta for a given fraction width.
    function automatic logic [63:0] satPattern(input logic negative, input int width);
        logic [63:0] span;
        span = 64'd1 << (width + 1);
        return negative ? (~span + 64'd1) : (span - 64'd1);
    endfunction

endpackage

// File: rtl/fp_unpack.sv
// Splits an IEEE-754 single into sign, hidden-bit mantissa and the alignment shift
// needed to place it on a theta grid with WIDTH fraction bits.
module fp_unpack
    import cordic_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SHW   = 5
)
(
    input  logic [31:0]      angle_i,
    output logic             sign_o,
    output logic [MANT_BITS:0] mant_o,
    output logic             shiftLeft_o,
    output logic [SHW-1:0]   shamt_o,
    output logic             zero_o,
    output logic             nan_o,
    output logic             overflow_o
);

    logic [7:0]           expField;
    logic [MANT_BITS-1:0] fracField;
    int                   expShift;
    int                   amount;

    assign sign_o    = angle_i[SIGN_BIT];
    assign expField  = angle_i[EXP_MSB:EXP_LSB];
    assign fracField = angle_i[MANT_MSB:0];
    assign mant_o    = {1'b1, fracField};

    // Positive expShift is a left shift; right shifts saturate at the full theta width.
    always_comb begin
        expShift = int'({24'd0, expField}) - EXP_BIAS - MANT_BITS + WIDTH;
        amount   = (expShift > 0) ? expShift : -expShift;
        if (amount > WIDTH + 2) begin
            amount = WIDTH + 2;
        end
        shiftLeft_o = (expShift > 0);
        shamt_o     = SHW'(amount);
        zero_o      = (expField == 8'd0);
        nan_o       = (expField == EXP_ALL_ONES) && (fracField != '0);
        overflow_o  = (int'({24'd0, expField}) >= EXP_OVF);
    end

endmodule

// File: rtl/float_to_fixed_angle.sv
// Multi-cycle float-to-theta converter: captures the angle on start, right-aligns it
// in SHIFT_STEP chunks, then applies the sign and pulses done.
module float_to_fixed_angle
    import cordic_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int SHIFT_STEP = 8
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             start,
    input  logic [31:0]      angle,
    output logic             busy,
    output logic             done,
    output logic [WIDTH+1:0] theta,
    output logic             overflow
);

    localparam int THETA_W = WIDTH + 2;
    localparam int MAGW    = (THETA_W > MANT_BITS + 1) ? THETA_W : MANT_BITS + 1;
    localparam int SHW     = $clog2(THETA_W + 1);

    localparam logic [SHW-1:0]     STEP    = SHW'(SHIFT_STEP);
    localparam logic [THETA_W-1:0] SAT_POS = THETA_W'(satPattern(1'b0, WIDTH));
    localparam logic [THETA_W-1:0] SAT_NEG = THETA_W'(satPattern(1'b1, WIDTH));
    localparam logic [MAGW-1:0]    SAT_MAG = MAGW'(satPattern(1'b0, WIDTH));

    logic               upSign;
    logic [MANT_BITS:0] upMant;
    logic               upShl;
    logic [SHW-1:0]     upShamt;
    logic               upZero;
    logic               upNan;
    logic               upOvf;

    state_e             state_q;
    logic [MAGW-1:0]    mag_q;
    logic [MAGW-1:0]    mag_d;
    logic [SHW-1:0]     remain_q;
    logic [SHW-1:0]     remain_d;
    logic               sign_q;
    logic               sat_q;
    logic               satNeg_q;
    logic               ovf_q;
    logic               busy_q;
    logic               done_q;
    logic [THETA_W-1:0] theta_q;
    logic [THETA_W-1:0] theta_d;
    logic               overflow_q;
    logic               alignLast;

    fp_unpack #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_unpack (
        .angle_i     (angle),
        .sign_o      (upSign),
        .mant_o      (upMant),
        .shiftLeft_o (upShl),
        .shamt_o     (upShamt),
        .zero_o      (upZero),
        .nan_o       (upNan),
        .overflow_o  (upOvf)
    );

    // Next magnitude/remaining shift for the capture in IDLE and each ALIGN step.
    always_comb begin
        mag_d     = mag_q;
        remain_d  = remain_q;
        alignLast = 1'b0;
        theta_d   = theta_q;
        case (state_q)
            IDLE: begin
                if (upZero) begin
                    mag_d    = '0;
                    remain_d = '0;
                end else if (upOvf) begin
                    mag_d    = SAT_MAG;
                    remain_d = '0;
                end else if (upShl) begin
                    mag_d    = MAGW'(upMant) << upShamt;
                    remain_d = '0;
                end else begin
                    mag_d    = MAGW'(upMant);
                    remain_d = upShamt;
                end
            end
            ALIGN: begin
                alignLast = (remain_q <= STEP);
                if (alignLast) begin
                    mag_d    = mag_q >> remain_q;
                    remain_d = '0;
                end else begin
                    mag_d    = mag_q >> SHIFT_STEP;
                    remain_d = remain_q - STEP;
                end
            end
            SIGN: begin
                if (sat_q) begin
                    theta_d = satNeg_q ? SAT_NEG : SAT_POS;
                end else begin
                    theta_d = THETA_W'(sign_q ? -mag_q : mag_q);
                end
            end
            default: begin
            end
        endcase
    end

    // Control FSM; nothing moves unless clk_en is high, reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            mag_q      <= '0;
            remain_q   <= '0;
            sign_q     <= 1'b0;
            sat_q      <= 1'b0;
            satNeg_q   <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            theta_q    <= '0;
            overflow_q <= 1'b0;
        end else if (clk_en) begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sign_q   <= upSign;
                        sat_q    <= upOvf;
                        satNeg_q <= upSign & ~upNan;
                        ovf_q    <= upOvf;
                        mag_q    <= mag_d;
                        remain_q <= remain_d;
                        busy_q   <= 1'b1;
                        state_q  <= ALIGN;
                    end
                end
                ALIGN: begin
                    mag_q    <= mag_d;
                    remain_q <= remain_d;
                    if (alignLast) begin
                        state_q <= SIGN;
                    end
                end
                SIGN: begin
                    theta_q    <= theta_d;
                    overflow_q <= ovf_q;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign theta    = theta_q;
    assign overflow = overflow_q;

endmodule
